// File: rtl/regfile_mp_sb_if.sv
// Register-file access bundle: read ports, write ports, scoreboard and debug tap.
// The master drives addresses and write data; the slave (register file) returns data and busy state.
interface regfile_mp_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     pend_set;
    logic [ADDR_W-1:0]        pend_addr;
    logic [NUM_REGS-1:0]      busy_vec;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr, dbg_addr,
        input  rd_data, rd_busy, busy_vec, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr, dbg_addr,
        output rd_data, rd_busy, busy_vec, dbg_data
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port MIPS register file with r0 hardwired to zero, optional write-to-read bypass,
// per-register pending-write scoreboard and a registered debug tap.
module regfile_mp_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1,
    parameter int unsigned BYPASS = 1
) (
    input logic           clk,
    input logic           rst,
    regfile_mp_sb_if.slave bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [DATA_W-1:0]   dbg_q;
    logic [DATA_W-1:0]   dbg_d;

    logic [ADDR_W-1:0] wa     [NUM_WR];
    logic [DATA_W-1:0] wd     [NUM_WR];
    logic [NUM_WR-1:0] wr_act;
    logic [ADDR_W-1:0] ra     [NUM_RD];

    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;

    // Unpack the flat port buses; a write is live only when enabled and not aimed at r0.
    for (genvar i = 0; i < int'(NUM_WR); i++) begin : g_wr
        assign wa[i]     = bus.wr_addr[i*ADDR_W +: ADDR_W];
        assign wd[i]     = bus.wr_data[i*DATA_W +: DATA_W];
        assign wr_act[i] = bus.wr_en[i] && (wa[i] != '0);
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        assign ra[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
    end

    // Next array contents: later write ports overwrite earlier ones on an address clash.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < int'(NUM_WR); i++) begin
            if (wr_act[i]) begin
                mem_d[wa[i]] = wd[i];
            end
        end
    end

    // Scoreboard next state: clears from completing writes, then sets from issue so set wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < int'(NUM_WR); i++) begin
            if (wr_act[i]) begin
                busy_d[wa[i]] = 1'b0;
            end
        end
        if (bus.pend_set && (bus.pend_addr != '0)) begin
            busy_d[bus.pend_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Debug tap samples the array as it stands before this edge's writes.
    always_comb begin
        dbg_d = '0;
        if (bus.dbg_addr != '0) begin
            dbg_d = mem_q[bus.dbg_addr];
        end
    end

    // Combinational read ports with optional forwarding from the highest matching write port.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            if (ra[k] != '0) begin
                rd_data_c[k*DATA_W +: DATA_W] = mem_q[ra[k]];
                rd_busy_c[k]                  = busy_q[ra[k]];
                if (BYPASS != 0) begin
                    for (int i = 0; i < int'(NUM_WR); i++) begin
                        if (wr_act[i] && (wa[i] == ra[k])) begin
                            rd_data_c[k*DATA_W +: DATA_W] = wd[i];
                            rd_busy_c[k]                  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
            dbg_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            dbg_q  <= dbg_d;
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_vec = busy_q;
    assign bus.dbg_data = dbg_q;
endmodule
